// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, constants and helpers for the FIFO enqueue arbiter
// Purpose: FSM state encoding, default payload width / ID tag position and a
//          ceil-log2 helper used to size the source-ID field.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int DEF_DW     = 32;
    // Bit position of the source-ID tag inside fifo_d_in for the default width
    localparam int ID_TAG_LSB = DEF_DW;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - rotating priority encoder
// Purpose: returns the first set bit of i_req searching upward from i_start,
//          wrapping modulo NREQ (NREQ need not be a power of two).
// Ports:
//   i_req    in   NREQ  request vector
//   i_start  in   IDW   index searched first
//   o_found  out  1     at least one request set
//   o_index  out  IDW   selected index (0 when none found)
import fifo_arb_pkg::*;

module rr_prio_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_start,
    output logic            o_found,
    output logic [IDW-1:0]  o_index
);

    logic [IDW:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest valid request wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_start} + (IDW+1)'(k);
            if (w_pos >= (IDW+1)'(NREQ)) w_pos = w_pos - (IDW+1)'(NREQ);
            if (i_req[w_pos[IDW-1:0]]) begin
                o_found = 1'b1;
                o_index = w_pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_enq_rr_arbiter.sv
// rtl/fifo_enq_rr_arbiter.sv - round-robin, burst-locked arbiter for one FIFO enqueue port
// Purpose: shares a FIFO ENQ/D_IN port among NREQ requesters, tags each beat
//          with its source ID and sequences a one-cycle FIFO clear on flush.
// Ports:
//   CLK, RST      clock and synchronous active-high reset
//   req_valid     in   NREQ     per-requester beat valid
//   req_data      in   NREQ*DW  payloads, requester i at [i*DW +: DW]
//   req_ready     out  NREQ     one-hot accept strobe (or zero)
//   flush         in   1        request FIFO clear
//   fifo_full_n   in   1        FIFO not full
//   fifo_empty_n  in   1        FIFO not empty
//   fifo_enq      out  1        FIFO enqueue
//   fifo_d_in     out  IDW+DW   {grant_id, payload}
//   fifo_clr      out  1        FIFO clear
//   grant_id      out  IDW      current grantee
//   busy          out  1        arbiter not idle or FIFO holds data
import fifo_arb_pkg::*;

module fifo_enq_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 32,
    parameter int IDW   = clog2(NREQ),
    parameter int BURST = 4,
    parameter int CW    = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    input  logic                 fifo_full_n,
    input  logic                 fifo_empty_n,
    output logic                 fifo_enq,
    output logic [IDW+DW-1:0]    fifo_d_in,
    output logic                 fifo_clr,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_owner;
    logic [CW-1:0]   r_burst_cnt;

    logic [DW-1:0]   w_data [NREQ];
    logic            w_owner_valid;
    logic            w_lock_hold;
    logic            w_found;
    logic            w_grant_valid;
    logic            w_accept;
    logic            w_burst_done;
    logic [IDW-1:0]  w_owner_next;
    logic [IDW-1:0]  w_start;
    logic [IDW-1:0]  w_pick;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_grant_next;

    function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + IDW'(1);
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign w_data[g] = req_data[g*DW +: DW];
    end

    assign w_owner_valid = req_valid[r_owner];
    assign w_lock_hold   = (r_state == ST_LOCK) && w_owner_valid;
    assign w_owner_next  = f_inc(r_owner);

    // A lock whose owner went idle releases immediately; the search then
    // begins just past the old owner so it cannot win again this cycle.
    assign w_start = (r_state == ST_LOCK) ? w_owner_next : r_rr_ptr;

    rr_prio_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req   (req_valid),
        .i_start (w_start),
        .o_found (w_found),
        .o_index (w_pick)
    );

    assign w_grant       = w_lock_hold ? r_owner : w_pick;
    assign w_grant_valid = w_lock_hold | w_found;
    assign w_grant_next  = f_inc(w_grant);
    assign w_accept      = w_grant_valid && fifo_full_n && (r_state != ST_FLUSH) && !RST;
    assign w_burst_done  = (r_burst_cnt + CW'(1)) == CW'(BURST);

    assign fifo_enq  = w_accept;
    assign req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;
    assign fifo_clr  = (r_state == ST_FLUSH) && !RST;
    assign grant_id  = w_grant;
    assign fifo_d_in = {w_grant, w_data[w_grant]};
    assign busy      = (r_state != ST_IDLE) || fifo_empty_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOCK: begin
                    if (w_lock_hold) begin
                        // A stalled beat leaves the count and lock untouched.
                        if (w_accept) begin
                            if (w_burst_done) begin
                                r_rr_ptr    <= w_owner_next;
                                r_burst_cnt <= '0;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_burst_cnt <= r_burst_cnt + CW'(1);
                            end
                        end
                    end else begin
                        if (r_state == ST_LOCK) begin
                            r_rr_ptr    <= w_owner_next;
                            r_burst_cnt <= '0;
                            r_state     <= ST_IDLE;
                        end
                        if (w_accept) begin
                            if (BURST == 1) begin
                                r_rr_ptr <= w_grant_next;
                            end else begin
                                r_owner     <= w_grant;
                                r_burst_cnt <= CW'(1);
                                r_state     <= ST_LOCK;
                            end
                        end
                    end
                    // A beat accepted alongside flush is still enqueued, then cleared.
                    if (flush) r_state <= ST_FLUSH;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_enq_rr_arbiter.sv
// tb/tb_fifo_enq_rr_arbiter.sv - directed scoreboard bench for fifo_enq_rr_arbiter
module tb_fifo_enq_rr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic                flush;
    logic                fifo_full_n;
    logic                fifo_empty_n;

    logic [NREQ-1:0]     b1_ready, b4_ready;
    logic                b1_enq, b4_enq;
    logic [IDW+DW-1:0]   b1_d_in, b4_d_in;
    logic                b1_clr, b4_clr;
    logic [IDW-1:0]      b1_gid, b4_gid;
    logic                b1_busy, b4_busy;

    int                  n_assert = 0;
    int                  n_fail   = 0;
    int                  sb1[$];
    int                  sb4[$];
    logic [DW-1:0]       data_tab [NREQ];

    always #5 CLK = ~CLK;

    fifo_enq_rr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .BURST(1), .CW(3)) u_b1 (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_ready(b1_ready), .flush(flush), .fifo_full_n(fifo_full_n),
        .fifo_empty_n(fifo_empty_n), .fifo_enq(b1_enq), .fifo_d_in(b1_d_in),
        .fifo_clr(b1_clr), .grant_id(b1_gid), .busy(b1_busy)
    );

    fifo_enq_rr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .BURST(4), .CW(3)) u_b4 (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_ready(b4_ready), .flush(flush), .fifo_full_n(fifo_full_n),
        .fifo_empty_n(fifo_empty_n), .fifo_enq(b4_enq), .fifo_d_in(b4_d_in),
        .fifo_clr(b4_clr), .grant_id(b4_gid), .busy(b4_busy)
    );

    task automatic chk(input string tag, input logic [IDW+DW-1:0] obs, input logic [IDW+DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // e_id < 0 means the grant is don't-care when no beat is expected.
    task automatic step(input int which, input bit e_enq, input int e_id, input bit e_clr);
        logic              enq, clr;
        logic [NREQ-1:0]   rdy;
        logic [IDW-1:0]    gid;
        logic [IDW+DW-1:0] din;
        int                id;
        string             p;
        p = $sformatf("u%0d_t%0t", which, $time);
        if (which == 1) begin
            enq = b1_enq; clr = b1_clr; rdy = b1_ready; gid = b1_gid; din = b1_d_in;
            if (e_enq) sb1.push_back(e_id);
        end else begin
            enq = b4_enq; clr = b4_clr; rdy = b4_ready; gid = b4_gid; din = b4_d_in;
            if (e_enq) sb4.push_back(e_id);
        end
        chk({p, "_enq"}, enq, e_enq);
        chk({p, "_clr"}, clr, e_clr);
        if (enq) begin
            id = -1;
            if (which == 1) begin
                chk({p, "_sb_nonempty"}, sb1.size() != 0, 1);
                if (sb1.size() != 0) id = sb1.pop_front();
            end else begin
                chk({p, "_sb_nonempty"}, sb4.size() != 0, 1);
                if (sb4.size() != 0) id = sb4.pop_front();
            end
            if (id >= 0) begin
                chk({p, "_grant_id"}, gid, id[IDW-1:0]);
                chk({p, "_tag"}, din[ID_TAG_LSB +: IDW], id[IDW-1:0]);
                chk({p, "_payload"}, din[DW-1:0], data_tab[id[IDW-1:0]]);
                chk({p, "_ready"}, rdy, 4'b0001 << id);
            end
        end else begin
            chk({p, "_ready_zero"}, rdy, '0);
            if (e_id >= 0) chk({p, "_grant_hold"}, gid, e_id[IDW-1:0]);
        end
    endtask

    task automatic cyc(input logic [NREQ-1:0] v, input bit fn, input bit fl,
                       input bit e_enq, input int e_id, input bit e_clr);
        @(negedge CLK);
        RST = 1'b0; req_valid = v; fifo_full_n = fn; flush = fl;
        #1;
        step(4, e_enq, e_id, e_clr);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; req_valid = '1; flush = 1'b0; fifo_full_n = 1'b1;
        #1;
        step(1, 1'b0, -1, 1'b0);
        step(4, 1'b0, -1, 1'b0);
    endtask

    initial begin
        int exp2 [12] = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1};
        for (int i = 0; i < NREQ; i++) begin
            data_tab[i] = 32'hC0DE_0000 + 32'(i * 32'h1111);
            req_data[i*DW +: DW] = data_tab[i];
        end
        RST = 1'b1; req_valid = '0; flush = 1'b0; fifo_full_n = 1'b1; fifo_empty_n = 1'b0;

        // Reset state and outputs held low during RST
        do_reset();
        do_reset();

        // BURST=1 strict rotation; BURST=4 instance gives 4 beats per owner
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            RST = 1'b0; req_valid = 4'b1111; fifo_full_n = 1'b1; flush = 1'b0;
            #1;
            step(1, 1'b1, k % 4, 1'b0);
            step(4, 1'b1, k / 4, 1'b0);
        end

        // Two requesters alternate in bursts of 4
        do_reset();
        for (int k = 0; k < 12; k++) cyc(4'b1010, 1'b1, 1'b0, 1'b1, exp2[k], 1'b0);

        // Stall mid-burst keeps the lock and the count
        do_reset();
        cyc(4'b0100, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        for (int k = 0; k < 3; k++) cyc(4'b1111, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 3, 1'b0);

        // Owner drop releases in the same cycle; search continues past the owner with wrap
        do_reset();
        cyc(4'b0001, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        cyc(4'b0011, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        cyc(4'b0010, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        cyc(4'b1101, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b1001, 1'b1, 1'b0, 1'b1, 3, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        // Idle with nothing pending: busy follows fifo_empty_n
        do_reset();
        cyc(4'b0000, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        chk("busy_idle_empty", b4_busy, 1'b0);
        fifo_empty_n = 1'b1;
        #1;
        chk("busy_idle_nonempty", b4_busy, 1'b1);
        fifo_empty_n = 1'b0;

        // Flush pulse during a lock, then flush held high
        do_reset();
        cyc(4'b1000, 1'b1, 1'b0, 1'b1, 3, 1'b0);
        cyc(4'b1000, 1'b1, 1'b1, 1'b1, 3, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, -1, 1'b1);
        chk("busy_flush", b4_busy, 1'b1);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        cyc(4'b1111, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        cyc(4'b1111, 1'b1, 1'b1, 1'b0, -1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        cyc(4'b1111, 1'b1, 1'b1, 1'b0, -1, 1'b1);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        // Reset mid-burst restarts the search at requester 0
        do_reset();
        for (int k = 0; k < 4; k++) cyc(4'b0100, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 3, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 3, 1'b0);
        do_reset();
        cyc(4'b1111, 1'b1, 1'b0, 1'b1, 0, 1'b0);

        chk("sb1_drain", sb1.size(), 0);
        chk("sb4_drain", sb4.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
